// File: rtl/pyramid_pkg.sv
// Shared types and defaults for the pyramid level writer.
// Word bundle carried from the packer through the output FIFO.
package pyramid_pkg;

  localparam int DEF_LUMA_BITS       = 8;
  localparam int DEF_PIXELS_PER_WORD = 4;
  localparam int DEF_ADDR_BITS       = 32;

  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0]                     addr;
    logic [DEF_LUMA_BITS*DEF_PIXELS_PER_WORD-1:0] data;
    logic [DEF_PIXELS_PER_WORD-1:0]               be;
  } mem_word_t;

  function automatic int lane_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pyramid_level_writer_sync_fifo.sv
// First-word-fall-through FIFO, sync active-low reset.
// Head entry reads as zero while empty.
module SyncFifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pyramid_level_writer.sv
// Packs decimated pixels into memory words and queues them
// for write-out with row/base addressing.
module pyramid_level_writer
  import pyramid_pkg::*;
#(
  parameter int LUMA_BITS       = DEF_LUMA_BITS,
  parameter int PIXELS_PER_WORD = DEF_PIXELS_PER_WORD,
  parameter int COORD_BITS      = 12,
  parameter int ADDR_BITS       = DEF_ADDR_BITS,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [COORD_BITS-1:0]                r_width,
  input  logic [ADDR_BITS-1:0]                 r_base_addr,
  input  logic [ADDR_BITS-1:0]                 r_stride,
  input  logic [LUMA_BITS-1:0]                 in_pixel,
  input  logic                                 in_valid,
  input  logic [COORD_BITS-1:0]                in_x,
  input  logic [COORD_BITS-1:0]                in_y,
  output logic [ADDR_BITS-1:0]                 mem_addr,
  output logic [LUMA_BITS*PIXELS_PER_WORD-1:0] mem_data,
  output logic [PIXELS_PER_WORD-1:0]           mem_be,
  output logic                                 mem_valid,
  input  logic                                 mem_ready,
  output logic                                 overflow,
  output logic                                 sync_err
);

  localparam int LW = lane_bits(PIXELS_PER_WORD);
  localparam int DW = LUMA_BITS * PIXELS_PER_WORD;
  localparam logic [COORD_BITS-1:0] LANE_MASK =
    COORD_BITS'(PIXELS_PER_WORD - 1);

  logic [DW-1:0]              acc_q, acc_d, acc_new;
  logic [PIXELS_PER_WORD-1:0] fill_q, fill_d, fill_new;
  logic [ADDR_BITS-1:0]       row_addr_q, row_addr_d, row_sel;
  logic [COORD_BITS-1:0]      exp_x_q, exp_x_d;
  logic                       overflow_q, overflow_d;
  logic                       sync_err_q, sync_err_d;
  logic [LW-1:0]              lane;
  logic                       last, push, push_ok;
  logic                       fifo_full, fifo_empty;
  mem_word_t                  push_word, pop_word;

  assign lane    = in_x[LW-1:0];
  assign last    = (in_x == r_width - COORD_BITS'(1));
  assign push_ok = !fifo_full || (mem_valid && mem_ready);

  // Contiguity check, lane packing, row addressing and push.
  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    row_addr_d = row_addr_q;
    exp_x_d    = exp_x_q;
    overflow_d = overflow_q;
    sync_err_d = sync_err_q;
    acc_new    = '0;
    fill_new   = '0;
    row_sel    = row_addr_q;
    push       = 1'b0;
    push_word  = '0;
    if (in_valid) begin
      if (in_x == '0) begin
        row_sel = (in_y == '0) ? r_base_addr
                               : row_addr_q + r_stride;
      end
      row_addr_d = row_sel;
      if (in_x != '0 && in_x != exp_x_q) begin
        sync_err_d = 1'b1;
        acc_d      = '0;
        fill_d     = '0;
        exp_x_d    = (in_x + COORD_BITS'(PIXELS_PER_WORD)) & ~LANE_MASK;
      end else begin
        acc_new  = (in_x == '0) ? '0 : acc_q;
        fill_new = (in_x == '0) ? '0 : fill_q;
        for (int i = 0; i < PIXELS_PER_WORD; i++) begin
          if (int'(lane) == i) begin
            acc_new[i*LUMA_BITS +: LUMA_BITS] = in_pixel;
            fill_new[i] = 1'b1;
          end
        end
        exp_x_d = last ? '0 : in_x + COORD_BITS'(1);
        if (int'(lane) == PIXELS_PER_WORD - 1 || last) begin
          push           = 1'b1;
          push_word.addr = row_sel + ADDR_BITS'(in_x >> LW);
          push_word.data = acc_new;
          push_word.be   = fill_new;
          acc_d          = '0;
          fill_d         = '0;
          if (!push_ok) overflow_d = 1'b1;
        end else begin
          acc_d  = acc_new;
          fill_d = fill_new;
        end
      end
    end
  end

  // Packer state and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q      <= '0;
      fill_q     <= '0;
      row_addr_q <= '0;
      exp_x_q    <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      row_addr_q <= row_addr_d;
      exp_x_q    <= exp_x_d;
      overflow_q <= overflow_d;
      sync_err_q <= sync_err_d;
    end
  end

  SyncFifo #(
    .WIDTH ($bits(mem_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push && push_ok),
    .wr_data (push_word),
    .full    (fifo_full),
    .rd_en   (mem_ready),
    .rd_data (pop_word),
    .empty   (fifo_empty)
  );

  assign mem_valid = !fifo_empty;
  assign mem_addr  = pop_word.addr;
  assign mem_data  = pop_word.data;
  assign mem_be    = pop_word.be;
  assign overflow  = overflow_q;
  assign sync_err  = sync_err_q;

endmodule
